// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg
//   Shared encodings for the register-file write arbiter.
//   arb_state_t : arbiter FSM states (2-bit)
//   wait_cnt_w  : width helper for the bounded-wait counter
package rf_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

    // Width of a counter that must represent 0..max_wait inclusive.
    function automatic int wait_cnt_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/rf_hold_buf.sv
// rf_hold_buf
//   One-entry holding register for a deferred MDU writeback.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     load            : capture load_rd/load_data, set full
//     clr             : drop the entry (load wins if both asserted)
//     load_rd/data    : entry to capture
//     full            : entry valid
//     buf_rd/buf_data : stored entry
module rf_hold_buf
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clr,
    input  logic [REG_ADDR_W-1:0] load_rd,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  full,
    output logic [REG_ADDR_W-1:0] buf_rd,
    output logic [DATA_W-1:0]     buf_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            buf_rd   <= '0;
            buf_data <= '0;
        end else if (load) begin
            full     <= 1'b1;
            buf_rd   <= load_rd;
            buf_data <= load_data;
        end else if (clr) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Arbitrates the single register-file write port between the pipeline
//   writeback stage (priority) and the multiply/divide unit. A blocked MDU
//   result parks in a one-entry buffer and drains on an idle writeback cycle;
//   after MAX_WAIT lost pipeline writes the pipeline is stalled for one cycle
//   to force the drain.
//   Ports:
//     clk, rst                    : clock, synchronous active-high reset
//     wb_enable/wb_rd/wb_data     : qualified pipeline write request
//     mdu_valid/mdu_rd/mdu_data   : MDU result, mdu_ready completes handshake
//     pipe_stall                  : pipeline must re-present WB inputs
//     rf_we/rf_waddr/rf_wdata     : registered register-file write port
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | buffer empty, MDU accepted (bypass or capture)
//   HELD  | buffer full, pipeline writes win, wait_cnt counts losses
//   FORCE | pipeline stalled, buffer drains this cycle
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_enable,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    output logic                  pipe_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata
);

    localparam int CNT_W = wait_cnt_w(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    arb_state_t            state, state_nxt;
    logic [CNT_W-1:0]      wait_cnt, cnt_nxt;

    logic                  buf_load, buf_clr, buf_full;
    logic [REG_ADDR_W-1:0] buf_rd;
    logic [DATA_W-1:0]     buf_data;

    logic                  sel_we;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  mdu_live;

    rf_hold_buf #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clr       (buf_clr),
        .load_rd   (mdu_rd),
        .load_data (mdu_data),
        .full      (buf_full),
        .buf_rd    (buf_rd),
        .buf_data  (buf_data)
    );

    // Writes to x0 are accepted from the MDU but never reach the file.
    assign mdu_live   = mdu_valid && (mdu_rd != '0);
    assign mdu_ready  = (state == ST_IDLE);
    // state is a flop, so this is a registered stall lasting one FORCE cycle.
    assign pipe_stall = (state == ST_FORCE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            rf_we    <= sel_we;
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        buf_load  = 1'b0;
        buf_clr   = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = rf_waddr;
        sel_data  = rf_wdata;

        case (state)
            ST_IDLE: begin
                if (wb_enable) begin
                    sel_we   = 1'b1;
                    sel_addr = wb_rd;
                    sel_data = wb_data;
                    if (mdu_live) begin
                        buf_load  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_HELD;
                    end
                end else if (mdu_live) begin
                    sel_we   = 1'b1;
                    sel_addr = mdu_rd;
                    sel_data = mdu_data;
                end
            end

            ST_HELD: begin
                if (!wb_enable) begin
                    sel_we    = buf_full;
                    sel_addr  = buf_rd;
                    sel_data  = buf_data;
                    buf_clr   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (wb_rd == buf_rd) begin
                    // Pipeline result is younger; the parked one is dead.
                    sel_we    = 1'b1;
                    sel_addr  = wb_rd;
                    sel_data  = wb_data;
                    buf_clr   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    sel_we   = 1'b1;
                    sel_addr = wb_rd;
                    sel_data = wb_data;
                    cnt_nxt  = wait_cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_MAX) begin
                        state_nxt = ST_FORCE;
                    end
                end
            end

            ST_FORCE: begin
                sel_we    = buf_full;
                sel_addr  = buf_rd;
                sel_data  = buf_data;
                buf_clr   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end

            default: begin
                buf_clr   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    rf_write_arbiter #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .MAX_WAIT   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_enable  (wb_enable),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mdu_valid  (mdu_valid),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_enable = 1'b0; wb_rd = '0; wb_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_rf got=%b/%0d/%h exp=0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        total++;
        if ({pipe_stall, mdu_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_ctl got stall=%b ready=%b exp stall=0 ready=1", pipe_stall, mdu_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hDEAD_BEEF;
        total++;
        if (mdu_ready !== 1'b1) begin
            bad++; $display("FAIL bypass_ready got=%b exp=1", mdu_ready);
        end
        tick();
        idle_inputs();
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL bypass_write got=%b/%0d/%h exp=1/7/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd7, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL bypass_hold got=%b/%0d/%h exp=0/7/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            mdu_valid = 1'b1; mdu_rd = 5'(12 + i); mdu_data = 32'hC0DE_0000 + 32'(i);
            tick();
            total++;
            if ({rf_we, rf_waddr, rf_wdata, mdu_ready} !==
                {1'b1, 5'(12 + i), 32'hC0DE_0000 + 32'(i), 1'b1}) begin
                bad++;
                $display("FAIL b2b_%0d got=%b/%0d/%h ready=%b exp=1/%0d/%h ready=1",
                         i, rf_we, rf_waddr, rf_wdata, mdu_ready, 12 + i, 32'hC0DE_0000 + 32'(i));
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_capture_drain();
        wb_enable = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
        mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h22;
        tick();
        idle_inputs();
        total++;
        if ({rf_we, rf_waddr, rf_wdata, mdu_ready} !== {1'b1, 5'd3, 32'h11, 1'b0}) begin
            bad++;
            $display("FAIL capture_wb got=%b/%0d/%h ready=%b exp=1/3/11 ready=0",
                     rf_we, rf_waddr, rf_wdata, mdu_ready);
        end
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata, mdu_ready} !== {1'b1, 5'd5, 32'h22, 1'b1}) begin
            bad++;
            $display("FAIL drain_buf got=%b/%0d/%h ready=%b exp=1/5/22 ready=1",
                     rf_we, rf_waddr, rf_wdata, mdu_ready);
        end
        tick();
        total++;
        if (rf_we !== 1'b0) begin
            bad++; $display("FAIL drain_after got we=%b exp=0", rf_we);
        end
    endtask

    task automatic test_force();
        wb_enable = 1'b1; wb_rd = 5'd1; wb_data = 32'h100;
        mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hA0;
        tick();
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        for (int i = 1; i <= 4; i++) begin
            wb_rd = 5'(1 + i); wb_data = 32'h100 + 32'(i);
            total++;
            if ({pipe_stall, mdu_ready} !== 2'b00) begin
                bad++;
                $display("FAIL force_wait_%0d got stall=%b ready=%b exp 0/0", i, pipe_stall, mdu_ready);
            end
            tick();
            total++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(1 + i), 32'h100 + 32'(i)}) begin
                bad++;
                $display("FAIL force_pipe_%0d got=%b/%0d/%h exp=1/%0d/%h",
                         i, rf_we, rf_waddr, rf_wdata, 1 + i, 32'h100 + 32'(i));
            end
        end
        wb_rd = 5'd6; wb_data = 32'h106;
        total++;
        if ({pipe_stall, mdu_ready} !== 2'b10) begin
            bad++;
            $display("FAIL force_stall got stall=%b ready=%b exp 1/0", pipe_stall, mdu_ready);
        end
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata, pipe_stall} !== {1'b1, 5'd10, 32'hA0, 1'b0}) begin
            bad++;
            $display("FAIL force_drain got=%b/%0d/%h stall=%b exp=1/10/a0 stall=0",
                     rf_we, rf_waddr, rf_wdata, pipe_stall);
        end
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata, mdu_ready} !== {1'b1, 5'd6, 32'h106, 1'b1}) begin
            bad++;
            $display("FAIL force_resume got=%b/%0d/%h ready=%b exp=1/6/106 ready=1",
                     rf_we, rf_waddr, rf_wdata, mdu_ready);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_same_rd();
        wb_enable = 1'b1; wb_rd = 5'd2; wb_data = 32'h20;
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
        tick();
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        wb_rd = 5'd9; wb_data = 32'h55;
        tick();
        wb_enable = 1'b0; wb_rd = '0; wb_data = '0;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, mdu_ready} !== {1'b1, 5'd9, 32'h55, 1'b1}) begin
            bad++;
            $display("FAIL same_rd_write got=%b/%0d/%h ready=%b exp=1/9/55 ready=1",
                     rf_we, rf_waddr, rf_wdata, mdu_ready);
        end
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd9, 32'h55}) begin
            bad++;
            $display("FAIL same_rd_drop got=%b/%0d/%h exp=0/9/55", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_rd_zero();
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h77;
        total++;
        if (mdu_ready !== 1'b1) begin
            bad++; $display("FAIL rd0_ready got=%b exp=1", mdu_ready);
        end
        tick();
        total++;
        if ({rf_we, mdu_ready} !== 2'b01) begin
            bad++; $display("FAIL rd0_discard got we=%b ready=%b exp we=0 ready=1", rf_we, mdu_ready);
        end
        wb_enable = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        tick();
        idle_inputs();
        total++;
        if ({rf_we, rf_waddr, rf_wdata, mdu_ready} !== {1'b1, 5'd4, 32'h44, 1'b1}) begin
            bad++;
            $display("FAIL rd0_with_wb got=%b/%0d/%h ready=%b exp=1/4/44 ready=1",
                     rf_we, rf_waddr, rf_wdata, mdu_ready);
        end
        tick();
        total++;
        if (rf_we !== 1'b0) begin
            bad++; $display("FAIL rd0_no_drain got we=%b exp=0", rf_we);
        end
    endtask

    task automatic test_reset_in_force();
        wb_enable = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
        mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'hBAD;
        tick();
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        for (int i = 0; i < 4; i++) begin
            wb_rd = 5'(2 + i);
            tick();
        end
        total++;
        if (pipe_stall !== 1'b1) begin
            bad++; $display("FAIL rstforce_enter got stall=%b exp=1", pipe_stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        total++;
        if ({pipe_stall, rf_we, rf_waddr, rf_wdata, mdu_ready} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL rstforce_out got stall=%b rf=%b/%0d/%h ready=%b exp stall=0 rf=0/0/0 ready=1",
                     pipe_stall, rf_we, rf_waddr, rf_wdata, mdu_ready);
        end
        tick();
        tick();
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            bad++;
            $display("FAIL rstforce_lost got=%b/%0d/%h exp=0/0/0", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_bypass();
        test_back_to_back();
        test_capture_drain();
        test_force();
        test_same_rd();
        test_rd_zero();
        test_reset_in_force();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
